// File: rtl/key_entry_frontend_if.sv
// Keypad-side signal bundle between the raw switch/button bank and the lock.
// master drives the raw inputs, slave is the frontend that produces digit events.
interface key_entry_frontend_if;
    logic [3:0] sw_raw;
    logic       btn_enter_raw;
    logic       btn_clear_raw;
    logic [3:0] code;
    logic       code_valid;
    logic [1:0] digit_idx;
    logic       entry_done;
    logic       entry_abort;
    logic       entry_timeout;
    logic       busy;

    modport master (
        output sw_raw, btn_enter_raw, btn_clear_raw,
        input  code, code_valid, digit_idx, entry_done, entry_abort, entry_timeout, busy
    );

    modport slave (
        input  sw_raw, btn_enter_raw, btn_clear_raw,
        output code, code_valid, digit_idx, entry_done, entry_abort, entry_timeout, busy
    );
endinterface

// File: rtl/key_entry_frontend.sv
// Keypad frontend: synchronises and debounces the buttons, then frames accepted
// enter presses into a 4-digit entry with abort and inactivity timeout.

module key_entry_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   differ;
    logic                   terminal;

    assign differ   = sync_q[SYNC_STAGES-1] != level_q;
    assign terminal = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    // Only an accepted 0->1 flip is an event; releases just re-arm the button.
    assign press    = terminal && sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (!differ) begin
                cnt_q <= '0;
            end else if (terminal) begin
                level_q <= sync_q[SYNC_STAGES-1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

module key_entry_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES  = 5000000,
    parameter int SYNC_STAGES     = 2
) (
    input logic           clk,
    input logic           rst,
    key_entry_frontend_if.slave bus
);
    // state      | meaning
    // ST_IDLE    | no digits held; next enter press delivers digit 0
    // ST_COLLECT | 1..3 digits held; next_idx_q is the index of the next digit
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;
    localparam int         TO_W       = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0][3:0] sw_sync_q;
    logic                        enter_press;
    logic                        clear_press;
    logic                        timeout_hit;
    logic [0:0]                  state_q;
    logic [1:0]                  next_idx_q;
    logic [TO_W-1:0]             idle_cnt_q;
    logic [3:0]                  code_q;
    logic                        code_valid_q;
    logic [1:0]                  digit_idx_q;
    logic                        done_q;
    logic                        abort_q;
    logic                        timeout_q;

    key_entry_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_enter (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.btn_enter_raw),
        .press(enter_press)
    );

    key_entry_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_clear (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.btn_clear_raw),
        .press(clear_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync_q <= '0;
        end else begin
            sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], bus.sw_raw};
        end
    end

    assign timeout_hit = (state_q == ST_COLLECT) &&
                         (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Priority: clear beats enter, enter beats the timeout terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            next_idx_q   <= 2'd0;
            idle_cnt_q   <= '0;
            code_q       <= 4'd0;
            code_valid_q <= 1'b0;
            digit_idx_q  <= 2'd0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            timeout_q    <= 1'b0;
            if (clear_press) begin
                abort_q     <= (state_q == ST_COLLECT);
                state_q     <= ST_IDLE;
                next_idx_q  <= 2'd0;
                digit_idx_q <= 2'd0;
                idle_cnt_q  <= '0;
            end else if (enter_press) begin
                code_q       <= sw_sync_q[SYNC_STAGES-1];
                code_valid_q <= 1'b1;
                digit_idx_q  <= next_idx_q;
                idle_cnt_q   <= '0;
                if (next_idx_q == 2'd3) begin
                    done_q     <= 1'b1;
                    state_q    <= ST_IDLE;
                    next_idx_q <= 2'd0;
                end else begin
                    state_q    <= ST_COLLECT;
                    next_idx_q <= next_idx_q + 2'd1;
                end
            end else if (timeout_hit) begin
                timeout_q   <= 1'b1;
                state_q     <= ST_IDLE;
                next_idx_q  <= 2'd0;
                digit_idx_q <= 2'd0;
                idle_cnt_q  <= '0;
            end else if (state_q == ST_COLLECT) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end else begin
                // Index 3 stays visible only on the completing strobe.
                digit_idx_q <= 2'd0;
            end
        end
    end

    assign bus.code          = code_q;
    assign bus.code_valid    = code_valid_q;
    assign bus.digit_idx     = digit_idx_q;
    assign bus.entry_done    = done_q;
    assign bus.entry_abort   = abort_q;
    assign bus.entry_timeout = timeout_q;
    assign bus.busy          = (state_q == ST_COLLECT);
endmodule

// File: tb/tb_key_entry_frontend.sv
// Bench for key_entry_frontend: directed scenarios plus randomized clean presses
// checked against an event-level model of the entry rules.
module tb_key_entry_frontend;
    localparam int DEB  = 4;
    localparam int TO   = 20;
    localparam int SYNC = 2;
    // Edges from driving a clean step to the strobe being visible.
    localparam int LAT  = SYNC + DEB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_entry_frontend_if bus();

    key_entry_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         r_cv, r_cv_at, r_ab, r_ab_at, r_to, r_to_at, r_dn;
    logic [3:0] r_code;
    logic [1:0] r_idx;
    logic       r_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sw_raw = 4'd0;
        bus.btn_enter_raw = 1'b0;
        bus.btn_clear_raw = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives one clean step (hold ticks high, then low ticks) and records what came out.
    task automatic press(input bit ent, input bit clr, input logic [3:0] sw,
                         input int hold, input int low);
        r_cv = 0; r_cv_at = -1; r_ab = 0; r_ab_at = -1; r_to = 0; r_to_at = -1; r_dn = 0;
        r_code = 4'd0; r_idx = 2'd0; r_done = 1'b0;
        bus.sw_raw = sw;
        bus.btn_enter_raw = ent && (hold > 0);
        bus.btn_clear_raw = clr && (hold > 0);
        for (int k = 1; k <= hold + low; k++) begin
            if (k == hold + 1) begin
                bus.btn_enter_raw = 1'b0;
                bus.btn_clear_raw = 1'b0;
            end
            tick();
            if (bus.code_valid) begin
                r_cv++; r_cv_at = k; r_code = bus.code; r_idx = bus.digit_idx; r_done = bus.entry_done;
            end
            if (bus.entry_done) r_dn++;
            if (bus.entry_abort) begin r_ab++; r_ab_at = k; end
            if (bus.entry_timeout) begin r_to++; r_to_at = k; end
        end
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst = 1'b1;
        bus.sw_raw = 4'hF;
        bus.btn_enter_raw = 1'b1;
        bus.btn_clear_raw = 1'b1;
        tick();
        tick();
        got = {bus.code, bus.code_valid, bus.digit_idx, bus.entry_done,
               bus.entry_abort, bus.entry_timeout, bus.busy};
        total++;
        if (got !== 11'd0) begin
            bad++; $display("FAIL reset_outputs: got %b want %b", got, 11'd0);
        end
        do_reset();
    endtask

    task automatic test_single_press();
        int n = 0;
        do_reset();
        bus.sw_raw = 4'h5;
        bus.btn_enter_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.code_valid === 1'b1) n++;
            if (k == LAT) begin
                total++;
                if (bus.code_valid !== 1'b1 || bus.code !== 4'h5 || bus.digit_idx !== 2'd0) begin
                    bad++;
                    $display("FAIL single_strobe: got cv=%b code=%h idx=%0d want cv=1 code=5 idx=0",
                             bus.code_valid, bus.code, bus.digit_idx);
                end
            end
            if (k == LAT - 1 || k == LAT + 1) begin
                total++;
                if (bus.busy !== (k == LAT + 1)) begin
                    bad++; $display("FAIL single_busy k=%0d: got %b want %b", k, bus.busy, k == LAT + 1);
                end
            end
        end
        total++;
        if (n !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", n); end
        bus.btn_enter_raw = 1'b0;
    endtask

    task automatic test_bounce();
        int n_bounce = 0;
        int n = 0;
        int at = -1;
        do_reset();
        bus.sw_raw = 4'h9;
        for (int i = 0; i < 12; i++) begin
            bus.btn_enter_raw = ((i / 2) % 2) == 0;
            tick();
            if (bus.code_valid === 1'b1) n_bounce++;
        end
        total++;
        if (n_bounce !== 0) begin bad++; $display("FAIL bounce_quiet: got %0d strobes want 0", n_bounce); end
        bus.btn_enter_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.code_valid === 1'b1) begin n++; at = k; end
        end
        total++;
        if (n !== 1 || at !== LAT) begin
            bad++; $display("FAIL bounce_strobe: got n=%0d at=%0d want n=1 at=%0d", n, at, LAT);
        end
        bus.btn_enter_raw = 1'b0;
    endtask

    task automatic test_four_digits();
        do_reset();
        for (int d = 0; d < 4; d++) begin
            press(1'b1, 1'b0, 4'(d + 1), 7, 7);
            total++;
            if (r_cv !== 1 || r_cv_at !== LAT || r_code !== 4'(d + 1) || r_idx !== 2'(d) ||
                r_done !== (d == 3) || r_dn !== int'(d == 3)) begin
                bad++;
                $display("FAIL four_digit%0d: got n=%0d at=%0d code=%h idx=%0d done=%b/%0d want n=1 at=%0d code=%h idx=%0d done=%b",
                         d, r_cv, r_cv_at, r_code, r_idx, r_done, r_dn, LAT, 4'(d + 1), d, d == 3);
            end
        end
        total++;
        if (bus.busy !== 1'b0 || bus.digit_idx !== 2'd0) begin
            bad++; $display("FAIL four_after: got busy=%b idx=%0d want busy=0 idx=0", bus.busy, bus.digit_idx);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        press(1'b1, 1'b0, 4'h1, 7, 7);
        press(1'b1, 1'b0, 4'h2, 7, 7);
        total++;
        if (r_idx !== 2'd1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL timeout_setup: got idx=%0d busy=%b want idx=1 busy=1", r_idx, bus.busy);
        end
        // Second strobe landed LAT ticks into a 14-tick call; timeout is TO after it.
        press(1'b0, 1'b0, 4'h0, 0, 20);
        total++;
        if (r_to !== 1 || r_to_at !== TO - (14 - LAT) || r_ab !== 0 || r_cv !== 0) begin
            bad++;
            $display("FAIL timeout_pulse: got n=%0d at=%0d abort=%0d cv=%0d want n=1 at=%0d abort=0 cv=0",
                     r_to, r_to_at, r_ab, r_cv, TO - (14 - LAT));
        end
        total++;
        if (bus.busy !== 1'b0 || bus.digit_idx !== 2'd0) begin
            bad++; $display("FAIL timeout_after: got busy=%b idx=%0d want 0 0", bus.busy, bus.digit_idx);
        end
        press(1'b1, 1'b0, 4'h3, 7, 7);
        total++;
        if (r_cv !== 1 || r_idx !== 2'd0 || r_code !== 4'h3) begin
            bad++; $display("FAIL timeout_restart: got n=%0d idx=%0d code=%h want 1 0 3", r_cv, r_idx, r_code);
        end
    endtask

    task automatic test_abort();
        do_reset();
        press(1'b1, 1'b0, 4'h7, 7, 7);
        press(1'b1, 1'b1, 4'h8, 7, 7);
        total++;
        if (r_cv !== 0 || r_ab !== 1 || r_ab_at !== LAT || r_to !== 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_both: got cv=%0d abort=%0d at=%0d to=%0d busy=%b want 0 1 %0d 0 0",
                     r_cv, r_ab, r_ab_at, r_to, bus.busy, LAT);
        end
        press(1'b0, 1'b1, 4'h0, 7, 7);
        total++;
        if (r_ab !== 0 || r_cv !== 0 || r_to !== 0) begin
            bad++; $display("FAIL abort_idle_clear: got abort=%0d cv=%0d to=%0d want 0 0 0", r_ab, r_cv, r_to);
        end
    endtask

    task automatic test_reset_mid_entry();
        logic [10:0] got;
        int n = 0;
        int at = -1;
        int n_ab = 0;
        int to_at = -1;
        do_reset();
        press(1'b1, 1'b0, 4'h1, 7, 7);
        press(1'b1, 1'b0, 4'h2, 7, 7);
        bus.sw_raw = 4'hC;
        bus.btn_enter_raw = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        got = {bus.code, bus.code_valid, bus.digit_idx, bus.entry_done,
               bus.entry_abort, bus.entry_timeout, bus.busy};
        total++;
        if (got !== 11'd0) begin bad++; $display("FAIL midreset_outputs: got %b want %b", got, 11'd0); end
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.code_valid === 1'b1) begin n++; at = k; end
            if (bus.entry_abort === 1'b1) n_ab++;
            if (bus.entry_timeout === 1'b1) to_at = k;
        end
        total++;
        if (n !== 1 || at !== LAT || n_ab !== 0 || to_at !== LAT + TO) begin
            bad++;
            $display("FAIL midreset_redebounce: got n=%0d at=%0d abort=%0d to_at=%0d want 1 %0d 0 %0d",
                     n, at, n_ab, to_at, LAT, LAT + TO);
        end
        bus.btn_enter_raw = 1'b0;
    endtask

    task automatic test_random();
        bit          m_coll = 1'b0;
        int          m_next = 0;
        int          m_last = 0;
        int          m_idx  = 0;
        int          mt     = 0;
        logic [3:0]  m_code = 4'd0;
        logic [10:0] exp_v, got_v;
        bit          e_cv, e_done, e_ab, e_to;
        do_reset();
        for (int op = 0; op < 60; op++) begin
            int         kind = $urandom_range(0, 9);
            bit         ent  = (kind <= 5) || (kind == 8);
            bit         clr  = (kind == 6) || (kind == 7) || (kind == 8);
            logic [3:0] sw   = 4'($urandom_range(0, 15));
            int         hold = (kind == 9) ? 0 : $urandom_range(7, 10);
            int         low  = $urandom_range(7, 30);
            bus.sw_raw = sw;
            bus.btn_enter_raw = ent && (hold > 0);
            bus.btn_clear_raw = clr && (hold > 0);
            for (int k = 1; k <= hold + low; k++) begin
                if (k == hold + 1) begin
                    bus.btn_enter_raw = 1'b0;
                    bus.btn_clear_raw = 1'b0;
                end
                tick();
                mt++;
                e_cv = 1'b0; e_done = 1'b0; e_ab = 1'b0; e_to = 1'b0;
                if (hold > 0 && k == LAT && clr) begin
                    e_ab = m_coll;
                    m_coll = 1'b0;
                    m_next = 0;
                end else if (hold > 0 && k == LAT && ent) begin
                    e_cv = 1'b1;
                    m_code = sw;
                    m_idx = m_next;
                    if (m_next == 3) begin
                        e_done = 1'b1; m_coll = 1'b0; m_next = 0;
                    end else begin
                        m_coll = 1'b1; m_next++; m_last = mt;
                    end
                end else if (m_coll && (mt - m_last) == TO) begin
                    e_to = 1'b1; m_coll = 1'b0; m_next = 0;
                end
                if (!e_cv && !m_coll) m_idx = 0;
                exp_v = {m_code, e_cv, 2'(m_idx), e_done, e_ab, e_to, m_coll};
                got_v = {bus.code, bus.code_valid, bus.digit_idx, bus.entry_done,
                         bus.entry_abort, bus.entry_timeout, bus.busy};
                total++;
                if (got_v !== exp_v) begin
                    bad++;
                    $display("FAIL random op%0d k%0d {code,cv,idx,done,abort,to,busy}: got %b want %b",
                             op, k, got_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        bus.sw_raw = 4'd0;
        bus.btn_enter_raw = 1'b0;
        bus.btn_clear_raw = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_four_digits();
        test_timeout();
        test_abort();
        test_reset_mid_entry();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
